md5_match_collector: RTL

MD5_MATCH_COLLECTOR -- requirements
Module: md5_match_collector

---
 rtl/md5_pkg.sv | 20 ++
 rtl/md5_digest_cmp.sv | 63 ++++++
 rtl/md5_match_collector.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// Shared types and helpers for the MD5 match collector.
// Holds the FSM state enum, digest width, default sizes and bswap32.
package md5_pkg;

    localparam int DIGEST_W  = 128;
    localparam int MSG_W_DEF = 448;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/md5_digest_cmp.sv
// Two-stage byte-swap and compare pipeline, carrying msg and ordinal.
// Ports: clk/reset, flush_i (drop in-flight entries), valid_i, a..d_i,
// msg_i, ord_i, target_i -> hit_o (stage-2 valid match), msg_o, ord_o.
module md5_digest_cmp
    import md5_pkg::*;
#(
    parameter int MSG_W = MSG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                valid_i,
    input  logic [31:0]         a_i,
    input  logic [31:0]         b_i,
    input  logic [31:0]         c_i,
    input  logic [31:0]         d_i,
    input  logic [MSG_W-1:0]    msg_i,
    input  logic [CNT_W-1:0]    ord_i,
    input  logic [DIGEST_W-1:0] target_i,
    output logic                hit_o,
    output logic [MSG_W-1:0]    msg_o,
    output logic [CNT_W-1:0]    ord_o
);

    logic                s1_valid_q;
    logic [DIGEST_W-1:0] s1_dig_q;
    logic [MSG_W-1:0]    s1_msg_q;
    logic [CNT_W-1:0]    s1_ord_q;
    logic                s2_valid_q;
    logic                s2_eq_q;
    logic [MSG_W-1:0]    s2_msg_q;
    logic [CNT_W-1:0]    s2_ord_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_dig_q   <= '0;
            s1_msg_q   <= '0;
            s1_ord_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_eq_q    <= 1'b0;
            s2_msg_q   <= '0;
            s2_ord_q   <= '0;
        end else begin
            // flush kills both stages so an aborted batch cannot hit
            s1_valid_q <= valid_i & ~flush_i;
            s1_dig_q   <= {bswap32(a_i), bswap32(b_i),
                           bswap32(c_i), bswap32(d_i)};
            s1_msg_q   <= msg_i;
            s1_ord_q   <= ord_i;
            s2_valid_q <= s1_valid_q & ~flush_i;
            s2_eq_q    <= (s1_dig_q == target_i);
            s2_msg_q   <= s1_msg_q;
            s2_ord_q   <= s1_ord_q;
        end
    end

    assign hit_o = s2_valid_q & s2_eq_q;
    assign msg_o = s2_msg_q;
    assign ord_o = s2_ord_q;

endmodule

// File: rtl/md5_match_collector.sv
// Collects a batch of md5core digests and captures the first match.
// Ports: start/target_hash/expected_count arm a batch; a..d_in, msg_in,
// valid_in feed digests; busy, done, match, match_index, match_msg report.
module md5_match_collector
    import md5_pkg::*;
#(
    parameter int MSG_W = MSG_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [127:0]        target_hash,
    input  logic [CNT_W-1:0]    expected_count,
    input  logic [31:0]         a_in,
    input  logic [31:0]         b_in,
    input  logic [31:0]         c_in,
    input  logic [31:0]         d_in,
    input  logic [MSG_W-1:0]    msg_in,
    input  logic                valid_in,
    output logic                busy,
    output logic                done,
    output logic                match,
    output logic [CNT_W-1:0]    match_index,
    output logic [MSG_W-1:0]    match_msg
);

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t              state_q;
    logic [DIGEST_W-1:0] target_q;
    logic [CNT_W-1:0]    exp_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                drain_q;
    logic                busy_q;
    logic                done_q;
    logic                match_q;
    logic [CNT_W-1:0]    idx_q;
    logic [MSG_W-1:0]    msg_q;

    logic                accept;
    logic                hit;
    logic                hit_new;
    logic [MSG_W-1:0]    hit_msg;
    logic [CNT_W-1:0]    hit_ord;

    assign accept = (state_q == RUN) && valid_in && !start
                    && (cnt_q < exp_q);

    md5_digest_cmp #(
        .MSG_W(MSG_W),
        .CNT_W(CNT_W)
    ) u_cmp (
        .clk     (clk),
        .reset   (reset),
        .flush_i (start),
        .valid_i (accept),
        .a_i     (a_in),
        .b_i     (b_in),
        .c_i     (c_in),
        .d_i     (d_in),
        .msg_i   (msg_in),
        .ord_i   (cnt_q),
        .target_i(target_q),
        .hit_o   (hit),
        .msg_o   (hit_msg),
        .ord_o   (hit_ord)
    );

    assign hit_new = hit & ~match_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            drain_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            idx_q    <= '0;
            msg_q    <= '0;
        end else if (start) begin
            target_q <= target_hash;
            exp_q    <= expected_count;
            cnt_q    <= '0;
            drain_q  <= 1'b0;
            match_q  <= 1'b0;
            idx_q    <= '0;
            msg_q    <= '0;
            if (expected_count == '0) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
        end else begin
            if (hit_new) begin
                match_q <= 1'b1;
                idx_q   <= hit_ord;
                msg_q   <= hit_msg;
            end
            unique case (state_q)
                RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_q + ONE;
                        if (cnt_q + ONE == exp_q) begin
                            state_q <= DRAIN;
                            drain_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stage-2 hit is forwarded so match shows two cycles after valid_in;
    // the capture registers then hold it until the next start.
    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q | hit_new;
    assign match_index = hit_new ? hit_ord : idx_q;
    assign match_msg   = hit_new ? hit_msg : msg_q;

endmodule
